// File: rtl/bomb_pkg.sv
// Shared types and default timing for the bomb pool: slot FSM encoding and tick counts.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FUSE  = 2'd1,
    BLAST = 2'd2
  } slot_state_e;

  localparam int FUSE_TICKS_DEF  = 72;
  localparam int BLAST_TICKS_DEF = 24;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> BLAST -> IDLE, a shared fuse/blast down-counter and latched position.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int TIMER_W     = 8,
  parameter int FUSE_TICKS  = FUSE_TICKS_DEF,
  parameter int BLAST_TICKS = BLAST_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_i,
  input  logic               alloc_i,
  input  logic               chain_hit_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output slot_state_e        state_o,
  output logic [TIMER_W-1:0] timer_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  localparam logic [TIMER_W-1:0] FUSE_LD  = TIMER_W'(FUSE_TICKS);
  localparam logic [TIMER_W-1:0] BLAST_LD = TIMER_W'(BLAST_TICKS);
  localparam logic [TIMER_W-1:0] ONE      = TIMER_W'(1);

  slot_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  // Allocation only happens from IDLE, so a tick in the accepting cycle never touches the new fuse.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (alloc_i) begin
          state_d = FUSE;
          timer_d = FUSE_LD;
          x_d     = x_i;
          y_d     = y_i;
        end
      end
      FUSE: begin
        if (tick_i) begin
          if (timer_q == ONE || chain_hit_i) begin
            state_d = BLAST;
            timer_d = BLAST_LD;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      BLAST: begin
        if (tick_i) begin
          if (timer_q == ONE) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign state_o = state_q;
  assign timer_o = timer_q;
  assign x_o     = x_q;
  assign y_o     = y_q;

endmodule

// File: rtl/bomb_pool.sv
// Pool of NUM_BOMBS timed bombs: priority allocation with duplicate rejection,
// chain detonation across blast bands, and packed per-slot status for the pixel logic.
module bomb_pool
  import bomb_pkg::*;
#(
  parameter int NUM_BOMBS   = 2,
  parameter int COORD_W     = 10,
  parameter int TIMER_W     = 8,
  parameter int FUSE_TICKS  = FUSE_TICKS_DEF,
  parameter int BLAST_TICKS = BLAST_TICKS_DEF,
  parameter int BLAST_HALF  = 26,
  parameter int BLINK_BIT   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         place_req,
  input  logic [COORD_W-1:0]           place_x,
  input  logic [COORD_W-1:0]           place_y,
  output logic                         place_ack,
  output logic                         place_rej,
  output logic [NUM_BOMBS-1:0]         bomb_fuse,
  output logic [NUM_BOMBS-1:0]         bomb_visible,
  output logic [NUM_BOMBS-1:0]         bomb_blast,
  output logic [NUM_BOMBS*COORD_W-1:0] bomb_x_flat,
  output logic [NUM_BOMBS*COORD_W-1:0] bomb_y_flat,
  output logic [3:0]                   active_count,
  output logic                         any_blast
);

  localparam logic [COORD_W:0]   HALF_W     = (COORD_W+1)'(BLAST_HALF);
  localparam logic [TIMER_W-1:0] BLINK_MASK = TIMER_W'(1) << BLINK_BIT;

  slot_state_e        st_w  [NUM_BOMBS];
  logic [TIMER_W-1:0] tmr_w [NUM_BOMBS];
  logic [COORD_W-1:0] x_w   [NUM_BOMBS];
  logic [COORD_W-1:0] y_w   [NUM_BOMBS];

  logic [NUM_BOMBS-1:0] idle_v, fuse_v, blast_v, pick_v, alloc_v, hit_v;
  logic                 dup, found, accept;
  logic                 ack_q, ack_d, rej_q, rej_d;
  logic [3:0]           cnt;

  // Band test on sign-extended differences so coordinates near 0 and full scale compare correctly.
  function automatic logic near(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] diff;
    logic [COORD_W:0]        mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = (diff < 0) ? -diff : diff;
    return mag <= HALF_W;
  endfunction

  for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
    bomb_slot #(
      .COORD_W     (COORD_W),
      .TIMER_W     (TIMER_W),
      .FUSE_TICKS  (FUSE_TICKS),
      .BLAST_TICKS (BLAST_TICKS)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .tick_i      (tick),
      .alloc_i     (alloc_v[g]),
      .chain_hit_i (hit_v[g]),
      .x_i         (place_x),
      .y_i         (place_y),
      .state_o     (st_w[g]),
      .timer_o     (tmr_w[g]),
      .x_o         (x_w[g]),
      .y_o         (y_w[g])
    );

    assign idle_v[g]  = (st_w[g] == IDLE);
    assign fuse_v[g]  = (st_w[g] == FUSE);
    assign blast_v[g] = (st_w[g] == BLAST);
    assign bomb_visible[g] = fuse_v[g] && ((tmr_w[g] & BLINK_MASK) == '0);
    assign bomb_x_flat[g*COORD_W +: COORD_W] = x_w[g];
    assign bomb_y_flat[g*COORD_W +: COORD_W] = y_w[g];
  end

  always_comb begin
    dup    = 1'b0;
    found  = 1'b0;
    pick_v = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (fuse_v[i] && x_w[i] == place_x && y_w[i] == place_y) dup = 1'b1;
      if (idle_v[i] && !found) begin
        pick_v[i] = 1'b1;
        found     = 1'b1;
      end
    end
    accept  = place_req && found && !dup;
    alloc_v = accept ? pick_v : '0;
    ack_d   = accept;
    rej_d   = place_req && !accept;
  end

  // Chain hits look only at registered BLAST states, so a triggered bomb lags its trigger by one tick.
  always_comb begin
    hit_v = '0;
    for (int j = 0; j < NUM_BOMBS; j++) begin
      for (int k = 0; k < NUM_BOMBS; k++) begin
        if (k != j && fuse_v[j] && blast_v[k] &&
            (near(x_w[j], x_w[k]) || near(y_w[j], y_w[k])))
          hit_v[j] = 1'b1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!idle_v[i]) cnt = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      rej_q <= rej_d;
    end
  end

  assign place_ack    = ack_q;
  assign place_rej    = rej_q;
  assign bomb_fuse    = fuse_v;
  assign bomb_blast   = blast_v;
  assign any_blast    = |blast_v;
  assign active_count = cnt;

endmodule

// File: tb/tb_bomb_pool.sv
// Randomised and directed bench for bomb_pool against a tick-counting reference model of the pool.
module tb_bomb_pool;

  localparam int NB = 2;
  localparam int CW = 10;
  localparam int FT = 72;
  localparam int BT = 24;
  localparam int BH = 26;
  localparam int BB = 3;
  localparam int OW = 2 + 3*NB + 1 + 4 + 2*NB*CW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0;
  logic             place_req = 1'b0;
  logic [CW-1:0]    place_x = '0;
  logic [CW-1:0]    place_y = '0;
  logic             place_ack, place_rej, any_blast;
  logic [NB-1:0]    bomb_fuse, bomb_visible, bomb_blast;
  logic [NB*CW-1:0] bomb_x_flat, bomb_y_flat;
  logic [3:0]       active_count;
  logic [OW-1:0]    obs, exp_v;

  int vecs = 0;
  int errs = 0;

  // Reference model: per slot phase (0 idle, 1 fuse, 2 blast), ticks elapsed in phase, position.
  int m_st [NB];
  int m_el [NB];
  int m_x  [NB];
  int m_y  [NB];
  bit m_ack, m_rej;

  bomb_pool #(
    .NUM_BOMBS(NB), .COORD_W(CW), .TIMER_W(8), .FUSE_TICKS(FT),
    .BLAST_TICKS(BT), .BLAST_HALF(BH), .BLINK_BIT(BB)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .place_req(place_req),
    .place_x(place_x), .place_y(place_y), .place_ack(place_ack), .place_rej(place_rej),
    .bomb_fuse(bomb_fuse), .bomb_visible(bomb_visible), .bomb_blast(bomb_blast),
    .bomb_x_flat(bomb_x_flat), .bomb_y_flat(bomb_y_flat),
    .active_count(active_count), .any_blast(any_blast)
  );

  assign obs = {place_ack, place_rej, bomb_fuse, bomb_visible, bomb_blast, any_blast,
                active_count, bomb_x_flat, bomb_y_flat};

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [OW-1:0] model_exp();
    logic [NB-1:0]    f, v, b;
    logic [3:0]       c;
    logic [NB*CW-1:0] xf, yf;
    f = '0; v = '0; b = '0; c = '0; xf = '0; yf = '0;
    for (int i = 0; i < NB; i++) begin
      f[i] = (m_st[i] == 1);
      v[i] = f[i] && ((((FT - m_el[i]) >> BB) % 2) == 0);
      b[i] = (m_st[i] == 2);
      if (m_st[i] != 0) c = c + 4'd1;
      xf[i*CW +: CW] = m_x[i][CW-1:0];
      yf[i*CW +: CW] = m_y[i][CW-1:0];
    end
    return {m_ack, m_rej, f, v, b, |b, c, xf, yf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_st[i] = 0; m_el[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_ack = 0; m_rej = 0;
    exp_v = model_exp();
  endtask

  task automatic model_next(input bit req, input int x, input int y, input bit tk);
    int ns [NB];
    int ne [NB];
    int fr;
    bit dup, ch;
    fr = -1; dup = 0;
    for (int i = NB-1; i >= 0; i--) begin
      if (m_st[i] == 0) fr = i;
      if (m_st[i] == 1 && m_x[i] == x && m_y[i] == y) dup = 1;
    end
    for (int i = 0; i < NB; i++) begin
      ns[i] = m_st[i]; ne[i] = m_el[i];
    end
    if (tk) begin
      for (int j = 0; j < NB; j++) begin
        if (m_st[j] == 1) begin
          ch = 0;
          for (int k = 0; k < NB; k++)
            if (k != j && m_st[k] == 2 &&
                (iabs(m_x[j] - m_x[k]) <= BH || iabs(m_y[j] - m_y[k]) <= BH)) ch = 1;
          if (m_el[j] + 1 == FT || ch) begin ns[j] = 2; ne[j] = 0; end
          else ne[j] = m_el[j] + 1;
        end else if (m_st[j] == 2) begin
          if (m_el[j] + 1 == BT) begin ns[j] = 0; ne[j] = 0; end
          else ne[j] = m_el[j] + 1;
        end
      end
    end
    m_ack = req && (fr >= 0) && !dup;
    m_rej = req && !m_ack;
    if (m_ack) begin
      ns[fr] = 1; ne[fr] = 0; m_x[fr] = x; m_y[fr] = y;
    end
    m_st = ns;
    m_el = ne;
  endtask

  task automatic step(input bit req, input int x, input int y, input bit tk);
    place_req = req; place_x = CW'(x); place_y = CW'(y); tick = tk;
    model_next(req, x, y, tk);
    exp_v = model_exp();
    @(posedge clk);
    #1;
    place_req = 1'b0; tick = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 330; c++) step(0, 0, 0, (c % 3) == 2);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL reset_state got=%h want=0", obs); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int ticks, bt;
    bit done;
    step(1, 100, 240, 0);
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL single_ack got=%h want=%h", obs, exp_v); end
    vecs++;
    if ({place_ack, bomb_fuse} !== 3'b101) begin
      errs++; $display("FAIL single_slot0 got=%b want=101", {place_ack, bomb_fuse});
    end
    ticks = 0; bt = -1; done = 0;
    for (int c = 0; c < 900 && !done; c++) begin
      step(0, 0, 0, (c % 3) == 2);
      if ((c % 3) == 2) ticks++;
      vecs++;
      if (obs !== exp_v) begin errs++; if (errs < 20) $display("FAIL single_run got=%h want=%h", obs, exp_v); end
      if (bomb_blast[0] && bt < 0) bt = ticks;
      if (bt >= 0 && active_count == 0) begin
        done = 1;
        vecs++;
        if (ticks - bt !== BT) begin errs++; $display("FAIL blast_len got=%0d want=%0d", ticks - bt, BT); end
      end
    end
    vecs++;
    if (bt !== FT) begin errs++; $display("FAIL fuse_len got=%0d want=%0d", bt, FT); end
    vecs++;
    if (!done) begin errs++; $display("FAIL single_timeout got=busy want=idle"); end
  endtask

  task automatic test_fill();
    bit freed;
    step(1, 10, 10, 0);
    vecs++;
    if ({place_ack, place_rej} !== 2'b10 || obs !== exp_v) begin
      errs++; $display("FAIL fill_first got=%h want=%h", obs, exp_v);
    end
    step(1, 500, 500, 0);
    vecs++;
    if ({place_ack, place_rej, bomb_fuse} !== 4'b1011 || obs !== exp_v) begin
      errs++; $display("FAIL fill_second got=%h want=%h", obs, exp_v);
    end
    step(1, 900, 900, 0);
    vecs++;
    if ({place_ack, place_rej} !== 2'b01 || obs !== exp_v) begin
      errs++; $display("FAIL fill_full_rej got=%h want=%h", obs, exp_v);
    end
    freed = 0;
    for (int c = 0; c < 900 && !freed; c++) begin
      step(0, 0, 0, (c % 3) == 2);
      vecs++;
      if (obs !== exp_v) begin errs++; if (errs < 20) $display("FAIL fill_run got=%h want=%h", obs, exp_v); end
      if (!bomb_fuse[0] && !bomb_blast[0]) freed = 1;
    end
    vecs++;
    if (!freed) begin errs++; $display("FAIL fill_timeout got=busy want=idle"); end
    step(1, 300, 300, 0);
    vecs++;
    if ({place_ack, bomb_fuse[0]} !== 2'b11 || obs !== exp_v) begin
      errs++; $display("FAIL fill_reuse got=%h want=%h", obs, exp_v);
    end
    drain();
  endtask

  task automatic test_dup();
    step(1, 200, 100, 0);
    step(0, 0, 0, 0);
    step(1, 200, 100, 0);
    vecs++;
    if ({place_ack, place_rej, bomb_fuse} !== 4'b0101 || obs !== exp_v) begin
      errs++; $display("FAIL dup_rej got=%h want=%h", obs, exp_v);
    end
    step(0, 0, 0, 0);
    step(1, 300, 100, 0);
    vecs++;
    if ({place_ack, place_rej} !== 2'b10 || obs !== exp_v) begin
      errs++; $display("FAIL held_ack got=%h want=%h", obs, exp_v);
    end
    step(1, 300, 100, 0);
    vecs++;
    if ({place_ack, place_rej} !== 2'b01 || obs !== exp_v) begin
      errs++; $display("FAIL held_rej got=%h want=%h", obs, exp_v);
    end
    drain();
  endtask

  task automatic test_chain(input int bx, input int by, input bit chain, input string nm);
    int ticks, a_c, b_c, b_ticks;
    bit b_req, rq, tk;
    step(1, 100, 50, 0);
    vecs++;
    if (obs !== exp_v) begin errs++; $display("FAIL %s_a got=%h want=%h", nm, obs, exp_v); end
    ticks = 0; a_c = -1; b_c = -1; b_ticks = 0; b_req = 0;
    for (int c = 0; c < 1200 && b_c < 0; c++) begin
      tk = (c % 3) == 2;
      rq = !b_req && ticks == 10 && (c % 3) == 0;
      step(rq, bx, by, tk);
      if (rq) begin
        b_req = 1;
        vecs++;
        if (place_ack !== 1'b1) begin errs++; $display("FAIL %s_b_ack got=%b want=1", nm, place_ack); end
      end else if (b_req && tk) b_ticks++;
      if (tk) ticks++;
      vecs++;
      if (obs !== exp_v) begin errs++; if (errs < 20) $display("FAIL %s_run got=%h want=%h", nm, obs, exp_v); end
      if (bomb_blast[0] && a_c < 0) a_c = c;
      if (bomb_blast[1] && b_c < 0) b_c = c;
    end
    vecs++;
    if (b_c < 0) begin
      errs++; $display("FAIL %s_timeout got=no_blast want=blast", nm);
    end else if (chain) begin
      if (b_c !== a_c + 3) begin errs++; $display("FAIL %s_lag got=%0d want=%0d", nm, b_c, a_c + 3); end
    end else begin
      if (b_ticks !== FT) begin errs++; $display("FAIL %s_fuse got=%0d want=%0d", nm, b_ticks, FT); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    step(1, 100, 50, 0);
    step(1, 100, 60, 0);
    for (int c = 0; c < 900; c++) begin
      if (m_st[0] == 2 && m_st[1] == 1) break;
      step(0, 0, 0, (c % 3) == 2);
      vecs++;
      if (obs !== exp_v) begin errs++; if (errs < 20) $display("FAIL rmid_run got=%h want=%h", obs, exp_v); end
    end
    place_req = 1'b1; place_x = CW'(300); place_y = CW'(300); tick = 1'b1;
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL rmid_async got=%h want=0", obs); end
    @(posedge clk);
    #1;
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL rmid_held got=%h want=0", obs); end
    reset = 1'b0; place_req = 1'b0; tick = 1'b0;
    model_reset();
    step(0, 0, 0, 0);
    vecs++;
    if (obs !== '0) begin errs++; $display("FAIL rmid_no_ack got=%h want=0", obs); end
    step(1, 100, 50, 0);
    step(1, 700, 700, 0);
    vecs++;
    if (active_count !== 4'd2 || obs !== exp_v) begin
      errs++; $display("FAIL rmid_realloc got=%h want=%h", obs, exp_v);
    end
    drain();
  endtask

  task automatic test_random();
    int xs [5];
    int ys [5];
    xs = '{100, 110, 200, 400, 1000};
    ys = '{50, 60, 240, 300, 900};
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 7) == 0, xs[$urandom_range(0, 4)], ys[$urandom_range(0, 4)],
           $urandom_range(0, 2) == 0);
      vecs++;
      if (obs !== exp_v) begin errs++; if (errs < 20) $display("FAIL random got=%h want=%h", obs, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fill();
    test_dup();
    test_chain(400, 60, 1, "chain");
    test_chain(400, 300, 0, "no_chain");
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bomb_pool.md
# bomb_pool

Parametrised pool of timed bombs for the maze game, replacing the single hard-wired bomb register set in the top-level VGA game module. It accepts placement requests from the player logic and runs an independent fuse and blast timer for each of NUM_BOMBS slots on the game tick. It adds chain detonation between bombs. It publishes per-slot position, blink-visibility and blast status to the pixel/collision logic.

## Interface
Parameters:
- NUM_BOMBS, 2: number of bomb slots (1..8).
- COORD_W, 10: width of X/Y coordinates.
- TIMER_W, 8: tick-counter width; must hold max(FUSE_TICKS, BLAST_TICKS).
- FUSE_TICKS, 72: ticks from placement to detonation (3 s at the game tick).
- BLAST_TICKS, 24: ticks a blast stays active.
- BLAST_HALF, 26: half-width of the blast cross band, used for chain detection.
- BLINK_BIT, 3: fuse-timer bit that gates fuse visibility.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- tick, in, 1: one-cycle game-tick enable (e.g. DIV_CLK[21] edge-detected); all timers advance only on tick.
- place_req, in, 1: placement request, level sampled every clk.
- place_x, in, COORD_W: X coordinate of the bomb to place.
- place_y, in, COORD_W: Y coordinate of the bomb to place.
- place_ack, out, 1: one-cycle pulse, request accepted.
- place_rej, out, 1: one-cycle pulse, request refused (pool full or duplicate position).
- bomb_fuse, out, NUM_BOMBS: slot in FUSE state.
- bomb_visible, out, NUM_BOMBS: slot in FUSE and timer[BLINK_BIT]==0.
- bomb_blast, out, NUM_BOMBS: slot in BLAST state.
- bomb_x_flat, out, NUM_BOMBS*COORD_W: slot i X at bits [i*COORD_W +: COORD_W].
- bomb_y_flat, out, NUM_BOMBS*COORD_W: slot i Y, same packing.
- active_count, out, 4: number of non-IDLE slots.
- any_blast, out, 1: OR of bomb_blast.

## Operation
- Each slot runs an FSM with three states.
  - IDLE to FUSE on allocation; timer loads FUSE_TICKS; X/Y are latched.
  - FUSE to BLAST on tick when timer==1, or on tick when a chain hit occurs; timer loads BLAST_TICKS.
  - BLAST to IDLE on tick when timer==1; X/Y are retained, not cleared.
  - Any other tick in FUSE or BLAST decrements the timer.
- Allocation:
  - On a cycle with place_req=1, the request is accepted if some slot is IDLE and no FUSE slot holds an identical (x,y).
  - The lowest-index IDLE slot is taken.
  - A held place_req is accepted once and then re-evaluated each cycle. The player logic must deassert place_req after ack; a held request after the first ack produces place_rej (duplicate position).
- Chain hit: a FUSE slot j detonates on the tick when any slot k is in BLAST (registered state) and |x_j−x_k| ≤ BLAST_HALF or |y_j−y_k| ≤ BLAST_HALF.
  - Differences are computed at COORD_W+1 bits, signed.
- Decisions use registered state only. A slot leaving BLAST for IDLE this cycle is not allocatable until the next cycle.
- FUSE_TICKS=1 is legal: the bomb detonates on the first tick after placement.

## Timing
- Reset (async): all slots IDLE, timers 0, X/Y 0. All outputs 0.
- place_ack / place_rej are asserted in the cycle after the sampled place_req. Slot outputs update in the same cycle as place_ack.
- If tick coincides with the accepting cycle, the new bomb's timer is not decremented on that tick.
- Fuse duration: exactly FUSE_TICKS ticks after the ack cycle. Blast duration: exactly BLAST_TICKS ticks.
- A chain-detonated bomb enters BLAST one clk after the tick that evaluated the hit. It therefore lags its trigger by one tick of blast timing.
- Reset asserted mid-operation clears everything immediately. There is no pending ack after reset release.

## Structure
- Package bomb_pkg holds:
  - the slot state enum: IDLE=2'd0, FUSE=2'd1, BLAST=2'd2;
  - default tick constants FUSE_TICKS_DEF=72 and BLAST_TICKS_DEF=24.
- Sub-module bomb_slot contains one FSM, its timer and its latched X/Y. It takes an alloc strobe, tick and chain_hit, and outputs state, timer and position.
- The bomb_pool top contains:
  - the priority allocator and duplicate check;
  - the pairwise chain comparator array;
  - output packing and population count.

## Test plan
- Reset release, single place at (100,240) with no further requests: ack next cycle; bomb_fuse[0]=1. After 72 ticks bomb_blast[0]=1; after 24 more ticks the slot is IDLE and active_count=0.
- Fill the pool (NUM_BOMBS=2), then a third request: two acks, one rej. After slot 0 returns to IDLE, a new request is acked into slot 0.
- Duplicate: place (200,100) twice with slot 1 free: the second request gets rej.
- Chain: place A at (100,50), then B at (400,60) 10 ticks later. A blasts at tick 72; B enters BLAST on the next tick, not at its own tick 82.
- No chain: B at (400,300) with A at (100,50): B blasts exactly FUSE_TICKS after its ack.
- Assert reset mid-FUSE with tick, place_req and chain activity all present: all outputs are 0 asynchronously, and the pool is fully allocatable after release.
